// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared sizing helpers for the AXI-Stream level buffer and its storage.
// A package cannot see module parameters, so the width rules live here as
// constant functions that each module evaluates on its own DEPTH/DATA_WIDTH.
//   ptr_width(depth)   : read/write pointer width
//   level_width(depth) : width of level/pkt_count, able to hold 0..depth
//   entry_width(dw)    : stored entry width ({tlast, tdata})
// -----------------------------------------------------------------------------
package axis_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 4096;

  // Pointer indexes 0..depth-1; keep at least one bit for tiny buffers.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Counters must reach depth itself, hence depth+1 values.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Each entry carries tlast above the data bits.
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/axis_buffer_mem.sv
// -----------------------------------------------------------------------------
// axis_buffer_mem
// Simple dual-port storage: one synchronous write port, one asynchronous read
// port. Contents are never reset.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write entry
//   rd_addr : read address
//   rd_data : entry at rd_addr (combinational)
// -----------------------------------------------------------------------------
module axis_buffer_mem #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: the entry lands on the rising edge when wr_en is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port is asynchronous so the head entry is visible without a cycle
  // of read latency.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_level_buffer.sv
// -----------------------------------------------------------------------------
// axis_level_buffer
// AXI-Stream FIFO with tlast transport, optional cut-through bypass when empty,
// optional packet-store mode, occupancy/threshold flags and synchronous flush.
//   clk, arstn            : clock, asynchronous active-low reset
//   flush                 : synchronous clear of all contents
//   s_axis_tdata/tlast/tvalid, s_axis_tready : input stream
//   m_axis_tdata/tlast/tvalid, m_axis_tready : output stream
//   level                 : registered count of stored beats
//   pkt_count             : registered count of stored beats with tlast set
//   almost_full           : registered, level >= AF_THRESH
//   almost_empty          : registered, level <= AE_THRESH
// -----------------------------------------------------------------------------
module axis_level_buffer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter bit BYPASS      = 1'b1,
  parameter bit PACKET_MODE = 1'b0,
  parameter int AF_THRESH   = DEPTH - 1,
  parameter int AE_THRESH   = 1
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [level_width(DEPTH)-1:0] level,
  output logic [level_width(DEPTH)-1:0] pkt_count,
  output logic                          almost_full,
  output logic                          almost_empty
);

  localparam int PTR_W   = ptr_width(DEPTH);
  localparam int LVL_W   = level_width(DEPTH);
  localparam int ENTRY_W = entry_width(DATA_WIDTH);

  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_L     = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0] AE_L     = LVL_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam bit               AF_RESET = (AF_THRESH == 0);
  // Packet mode must see every beat stored, so it overrides bypass.
  localparam bit               BYPASS_EN = BYPASS && !PACKET_MODE;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] rd_entry;
  logic [LVL_W-1:0]   level_next;
  logic [LVL_W-1:0]   pkt_next;
  logic               active;
  logic               level_zero;
  logic               select_s;
  logic               bypass_take;
  logic               valid_raw;
  logic               wr_en;
  logic               rd_en;
  logic               pkt_inc;
  logic               pkt_dec;

  function automatic logic [PTR_W-1:0] ptr_advance(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  axis_buffer_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr),
    .wr_data({s_axis_tlast, s_axis_tdata}),
    .rd_addr(rd_ptr),
    .rd_data(rd_entry)
  );

  // Both handshakes are blocked while in reset or flushing.
  assign active      = arstn & ~flush;
  assign level_zero  = (level == '0);
  assign select_s    = BYPASS_EN & level_zero;
  assign bypass_take = select_s & s_axis_tvalid & m_axis_tready & active;

  // A full buffer still accepts when a read retires in the same cycle.
  assign s_axis_tready = active & ((level < DEPTH_L) | m_axis_tready);

  // Output valid depends on the mode. In packet mode a full buffer with no
  // tlast is released anyway so the stream cannot deadlock.
  always_comb begin
    valid_raw = 1'b0;
    if (PACKET_MODE) begin
      valid_raw = (pkt_count != '0) | (level == DEPTH_L);
    end else if (BYPASS_EN) begin
      valid_raw = ~level_zero | s_axis_tvalid;
    end else begin
      valid_raw = ~level_zero;
    end
  end

  assign m_axis_tvalid = active & valid_raw;
  assign m_axis_tdata  = select_s ? s_axis_tdata : rd_entry[DATA_WIDTH-1:0];
  assign m_axis_tlast  = select_s ? s_axis_tlast : rd_entry[DATA_WIDTH];

  assign wr_en   = s_axis_tvalid & s_axis_tready & ~bypass_take;
  assign rd_en   = m_axis_tvalid & m_axis_tready & ~level_zero;
  assign pkt_inc = wr_en & s_axis_tlast;
  assign pkt_dec = rd_en & rd_entry[DATA_WIDTH];

  // Next-state occupancy counters; flags are derived from these so they move
  // on the same edge as level.
  always_comb begin
    level_next = level;
    pkt_next   = pkt_count;
    if (flush) begin
      level_next = '0;
      pkt_next   = '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   level_next = level + 1'b1;
        2'b01:   level_next = level - 1'b1;
        default: level_next = level;
      endcase
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_next = pkt_count + 1'b1;
        2'b01:   pkt_next = pkt_count - 1'b1;
        default: pkt_next = pkt_count;
      endcase
    end
  end

  // Pointer, counter and flag registers. Flush clears everything except
  // storage contents, which are simply abandoned.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      pkt_count    <= '0;
      almost_full  <= AF_RESET;
      almost_empty <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= ptr_advance(wr_ptr);
        end
        if (rd_en) begin
          rd_ptr <= ptr_advance(rd_ptr);
        end
      end
      level        <= level_next;
      pkt_count    <= pkt_next;
      almost_full  <= (level_next >= AF_L);
      almost_empty <= (level_next <= AE_L);
    end
  end

endmodule
